// File: rtl/pwm_capture.sv
// PWM capture: measures period and high time of an asynchronous PWM line and
// converts them to an 8-bit duty (1/128 units) or servo position (0..255)
// with a 32-step restoring divider. Detects signal loss and dropped captures.
module pwm_capture #(
   parameter int CNT_W      = 24,
   parameter int TIMEOUT    = 400000,
   parameter int SERVO_MIN  = 10000,
   parameter int SERVO_SPAN = 10000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       pwm_in,
   input  logic       sel,
   output logic [7:0] duty_out,
   output logic       valid,
   output logic       busy,
   output logic       lost,
   output logic       overrun
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      DIV   = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
   localparam logic [31:0]      SMIN_C    = 32'(SERVO_MIN);
   localparam logic [31:0]      SMAX_C    = 32'(SERVO_MIN + SERVO_SPAN);
   localparam logic [31:0]      SSPAN_C   = 32'(SERVO_SPAN);

   // Quotient above the 8-bit range pins at full scale.
   function automatic logic [7:0] sat_u8(input logic [31:0] q);
      if (|q[31:8]) begin
         sat_u8 = 8'hFF;
      end else begin
         sat_u8 = q[7:0];
      end
   endfunction

   logic             s1_r, s2_r, s3_r;
   logic             rise_s;
   logic             timeout_s;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] high_r;
   state_t           state_r;
   logic [31:0]      quo_r;
   logic [31:0]      rem_r;
   logic [31:0]      den_r;
   logic [5:0]       iter_r;
   logic [31:0]      h32_s, hc_s, off_s, num_s, den_s;
   logic [32:0]      shift_s;
   logic [31:0]      trial_s;
   logic             ge_s;

   assign rise_s    = s2_r & ~s3_r;
   assign timeout_s = (cnt_r >= TIMEOUT_C);

   // Synchronize the PWM line and run the period / high-time counters.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         s1_r   <= 1'b0;
         s2_r   <= 1'b0;
         s3_r   <= 1'b0;
         cnt_r  <= '0;
         high_r <= '0;
      end else begin
         s1_r <= pwm_in;
         s2_r <= s1_r;
         s3_r <= s2_r;
         if (rise_s) begin
            // The rise cycle itself is the first cycle of the new period.
            cnt_r  <= CNT_ONE;
            high_r <= CNT_ONE;
         end else begin
            if (cnt_r != CNT_MAX) begin
               cnt_r <= cnt_r + CNT_ONE;
            end
            if (s2_r && (high_r != CNT_MAX)) begin
               high_r <= high_r + CNT_ONE;
            end
         end
      end
   end

   // Build divider operands from the live counters and mode at capture time.
   always_comb begin
      h32_s = 32'(high_r);
      if (h32_s < SMIN_C) begin
         hc_s = SMIN_C;
      end else if (h32_s > SMAX_C) begin
         hc_s = SMAX_C;
      end else begin
         hc_s = h32_s;
      end
      off_s = hc_s - SMIN_C;
      if (sel) begin
         num_s = (off_s << 5'd8) - off_s;
         den_s = SSPAN_C;
      end else begin
         num_s = h32_s << 5'd7;
         den_s = 32'(cnt_r);
      end
   end

   // One restoring-division step: shift in the next dividend bit, try subtract.
   always_comb begin
      shift_s = {rem_r, quo_r[31]};
      ge_s    = (shift_s >= {1'b0, den_r});
      trial_s = shift_s[31:0] - den_r;
   end

   // Control FSM with divider datapath and registered outputs.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state_r  <= IDLE;
         quo_r    <= 32'd0;
         rem_r    <= 32'd0;
         den_r    <= 32'd0;
         iter_r   <= 6'd0;
         duty_out <= 8'd0;
         valid    <= 1'b0;
         busy     <= 1'b0;
         lost     <= 1'b0;
         overrun  <= 1'b0;
      end else begin
         valid <= 1'b0;
         case (state_r)
            IDLE: begin
               busy <= 1'b0;
               if (rise_s) begin
                  state_r <= ARMED;
               end
            end
            ARMED: begin
               busy <= 1'b0;
               if (rise_s) begin
                  // A saturated period is meaningless; just restart counting.
                  if (cnt_r != CNT_MAX) begin
                     quo_r   <= num_s;
                     den_r   <= den_s;
                     rem_r   <= 32'd0;
                     iter_r  <= 6'd0;
                     state_r <= DIV;
                  end
               end else if (timeout_s) begin
                  state_r <= IDLE;
                  lost    <= 1'b1;
               end
            end
            DIV: begin
               if (timeout_s && !rise_s) begin
                  state_r <= IDLE;
                  lost    <= 1'b1;
                  busy    <= 1'b0;
               end else if (iter_r == 6'd32) begin
                  duty_out <= sat_u8(quo_r);
                  valid    <= 1'b1;
                  lost     <= 1'b0;
                  overrun  <= rise_s;
                  busy     <= 1'b0;
                  state_r  <= ARMED;
               end else begin
                  quo_r  <= {quo_r[30:0], ge_s};
                  rem_r  <= ge_s ? trial_s : shift_s[31:0];
                  iter_r <= iter_r + 6'd1;
                  busy   <= 1'b1;
                  if (rise_s) begin
                     overrun <= 1'b1;
                  end
               end
            end
            default: begin
               state_r <= IDLE;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture with scaled-down timeout and servo range.
module tb_pwm_capture;

   localparam int TMO = 10500;

   logic       clk;
   logic       rst_n;
   logic       pwm_in;
   logic       sel;
   logic [7:0] duty_out;
   logic       valid;
   logic       busy;
   logic       lost;
   logic       overrun;

   int cyc;
   int n_cmp;
   int n_err;
   int n_valid;
   int last_valid_cyc;
   int busy_rise_cyc;
   int busy_fall_cyc;
   int last_rise_cyc;
   int vbase;
   logic busy_prev;

   pwm_capture #(
      .CNT_W     (24),
      .TIMEOUT   (TMO),
      .SERVO_MIN (1000),
      .SERVO_SPAN(1000)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .pwm_in  (pwm_in),
      .sel     (sel),
      .duty_out(duty_out),
      .valid   (valid),
      .busy    (busy),
      .lost    (lost),
      .overrun (overrun)
   );

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycle counter advanced on every active edge.
   always @(posedge clk) cyc <= cyc + 1;

   // Record valid pulses and busy edges away from the active edge.
   always @(negedge clk) begin
      if (valid === 1'b1) begin
         n_valid        = n_valid + 1;
         last_valid_cyc = cyc;
      end
      if (busy === 1'b1 && busy_prev !== 1'b1) busy_rise_cyc = cyc;
      if (busy !== 1'b1 && busy_prev === 1'b1) busy_fall_cyc = cyc;
      busy_prev = busy;
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp = n_cmp + 1;
      if (obs !== exp) begin
         n_err = n_err + 1;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One PWM period: high for hi cycles, then low for lo cycles.
   task automatic pulse(input int hi, input int lo);
      pwm_in        = 1'b1;
      last_rise_cyc = cyc;
      wait_cyc(hi);
      pwm_in = 1'b0;
      wait_cyc(lo);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n  = 1'b1;
      pwm_in = 1'b0;
      wait_cyc(3);
      rst_n = 1'b0;
      wait_cyc(2);
   endtask

   int t1;

   initial begin
      cyc = 0; n_cmp = 0; n_err = 0; n_valid = 0;
      last_valid_cyc = 0; busy_rise_cyc = 0; busy_fall_cyc = 0;
      last_rise_cyc = 0; busy_prev = 1'b0; vbase = 0;
      rst_n = 1'b1; pwm_in = 1'b0; sel = 1'b0;

      // Reset state
      wait_cyc(3);
      check_eq("rst_duty", 32'(duty_out), 32'd0);
      check_eq("rst_flags", {28'd0, valid, busy, lost, overrun}, 32'd0);

      // Duty 25%: arm, then measure; latency and busy window
      do_reset();
      vbase = n_valid;
      pulse(250, 750);
      check_eq("arm_only", 32'(n_valid - vbase), 32'd0);
      pulse(250, 750);
      t1 = last_rise_cyc;
      check_eq("duty25_cnt", 32'(n_valid - vbase), 32'd1);
      check_eq("duty25", 32'(duty_out), 32'd32);
      check_eq("latency", 32'(last_valid_cyc - t1), 32'd36);
      check_eq("busy_rise", 32'(busy_rise_cyc - t1), 32'd4);
      check_eq("busy_fall", 32'(busy_fall_cyc - t1), 32'd36);

      // Floor check around 50%
      do_reset();
      pulse(5209, 5208);
      pulse(5208, 5209);
      check_eq("duty_64", 32'(duty_out), 32'd64);
      pulse(10, 40);
      check_eq("duty_63", 32'(duty_out), 32'd63);

      // Servo mode: mid, below-min clamp, above-max clamp with sel flip mid-divide
      do_reset();
      sel = 1'b1;
      pulse(1500, 1500);
      pulse(500, 2500);
      check_eq("servo_mid", 32'(duty_out), 32'd127);
      pulse(2500, 500);
      check_eq("servo_lo", 32'(duty_out), 32'd0);
      pwm_in = 1'b1;
      wait_cyc(10);
      sel = 1'b0;
      wait_cyc(30);
      pwm_in = 1'b0;
      wait_cyc(10);
      check_eq("servo_hi", 32'(duty_out), 32'd255);

      // Period equal to the timeout (rise wins), then loss and recovery
      do_reset();
      vbase = n_valid;
      pulse(250, 750);
      pulse(5250, 5250);
      check_eq("pre_lost", 32'(duty_out), 32'd32);
      pulse(250, 10700);
      check_eq("tmo_edge", 32'(duty_out), 32'd64);
      check_eq("lost_set", 32'(lost), 32'd1);
      check_eq("lost_nvld", 32'(n_valid - vbase), 32'd2);
      pulse(750, 250);
      check_eq("lost_hold", 32'(lost), 32'd1);
      check_eq("lost_arm", 32'(n_valid - vbase), 32'd2);
      pulse(750, 250);
      check_eq("lost_clr", 32'(lost), 32'd0);
      check_eq("resume", 32'(duty_out), 32'd96);

      // Overrun: rise inside the divide is dropped, result in flight completes
      do_reset();
      vbase = n_valid;
      pulse(5, 15);
      pulse(15, 5);
      pwm_in = 1'b1;
      wait_cyc(5);
      check_eq("ovr_set", 32'(overrun), 32'd1);
      check_eq("ovr_busy", 32'(busy), 32'd1);
      wait_cyc(45);
      pwm_in = 1'b0;
      wait_cyc(50);
      check_eq("ovr_inflight", 32'(duty_out), 32'd32);
      check_eq("ovr_cnt", 32'(n_valid - vbase), 32'd1);
      pulse(10, 40);
      check_eq("ovr_next", 32'(duty_out), 32'd64);
      check_eq("ovr_clr", 32'(overrun), 32'd0);

      // Reset in the middle of a divide
      do_reset();
      pulse(250, 750);
      pulse(250, 750);
      check_eq("pre_rst", 32'(duty_out), 32'd32);
      pwm_in = 1'b1;
      wait_cyc(13);
      check_eq("rst_busy_pre", 32'(busy), 32'd1);
      rst_n = 1'b1;
      #1;
      check_eq("rst_mid_duty", 32'(duty_out), 32'd0);
      check_eq("rst_mid_flags", {28'd0, valid, busy, lost, overrun}, 32'd0);
      pwm_in = 1'b0;
      wait_cyc(3);
      rst_n = 1'b0;
      vbase = n_valid;
      wait_cyc(60);
      check_eq("rst_novalid", 32'(n_valid - vbase), 32'd0);
      pulse(250, 750);
      check_eq("rst_arm", 32'(n_valid - vbase), 32'd0);
      pulse(250, 750);
      check_eq("rst_recover", 32'(n_valid - vbase), 32'd1);
      check_eq("rst_duty2", 32'(duty_out), 32'd32);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 Parameter CNT_W, default 24, is the width of the period and high-time counters.
REQ-002 Parameter TIMEOUT, default 400000, is the clk cycles without a rising edge before the signal is declared lost.
REQ-003 Parameter SERVO_MIN, default 10000, is the servo-mode pulse width mapped to 0 (1 ms at 10 MHz).
REQ-004 Parameter SERVO_SPAN, default 10000, is the servo-mode pulse width span mapped to 0..255.
REQ-005 clk  input  1  rising-edge system clock, 10 MHz nominal.
REQ-006 rst_n  input  1  reset, asynchronous, active-high (despite the name).
REQ-007 pwm_in  input  1  asynchronous PWM line under measurement.
REQ-008 sel  input  1  mode: 0 = duty mode (duty in 1/128 units), 1 = servo mode (pulse width mapped to 0..255).
REQ-009 duty_out  output  8  last measured value, held between measurements.
REQ-010 valid  output  1  one-cycle pulse when duty_out updates.
REQ-011 busy  output  1  high while the divider runs.
REQ-012 lost  output  1  level; set on timeout, cleared by the next valid.
REQ-013 overrun  output  1  sticky; set when a capture is dropped, cleared by the next valid.

Function
REQ-014 pwm_in SHALL pass through two synchronizer flops (s1, s2) plus a history flop s3; rise = s2 & ~s3.
REQ-015 A free counter SHALL count clk cycles since the last rise, saturating at 2^CNT_W-1.
REQ-016 A high counter SHALL count cycles with s2=1 since the last rise, including the rise cycle, saturating at 2^CNT_W-1.
REQ-017 FSM states and transitions SHALL be:
- IDLE: after reset or lost; the first rise moves to ARMED, clears both counters, and does not capture.
- ARMED: on each rise, capture P = cycles since the previous rise and H = high cycles in that period, restart both counters at the rise cycle, then go to DIV.
- DIV: 32 iterations of a restoring divide, one quotient bit per cycle; counting continues meanwhile; then return to ARMED.
REQ-018 For a PWM of period N cycles and high time K cycles, the captured values SHALL be exactly P=N and H=K.
REQ-019 In duty mode (sel=0), numerator = H<<7 and denominator = P, so duty_out = floor(H*128/P); 100% duty is not measurable (no edge).
REQ-020 In servo mode (sel=1), Hc = clamp(H, SERVO_MIN, SERVO_MIN+SERVO_SPAN), numerator = (Hc-SERVO_MIN)*255, denominator = SERVO_SPAN.
REQ-021 sel SHALL be sampled at the capture cycle; a sel change mid-division SHALL NOT affect the result in progress.
REQ-022 Divider operands SHALL be 32 bits; a quotient above 255 SHALL saturate to 255.
REQ-023 The divide SHALL start the cycle after capture (C); at C+33, duty_out loads, valid=1 for one cycle, lost and overrun clear, and busy falls.
- Latency from the raw pwm_in edge to valid is 3+33 = 36 cycles.
REQ-024 busy SHALL be 1 from C+1 through C+32 inclusive.
REQ-025 A rise during DIV SHALL restart the counters but drop its capture, set overrun, and leave the running divide unaffected.
REQ-026 If the cycles-since-rise counter reaches TIMEOUT in any state other than IDLE, the block SHALL go to IDLE and set lost=1.
- duty_out is held and no valid is issued.
- A divide in progress at the timeout is aborted.
REQ-027 If a rise and the timeout occur in the same cycle, the rise SHALL take priority and no timeout is declared.
REQ-028 A period whose counter saturated SHALL NOT be captured; the timeout path handles it.

Reset
REQ-029 While rst_n=1, all flops SHALL clear immediately: FSM=IDLE, counters=0, s1/s2/s3=0, duty_out=0, valid=0, busy=0, lost=0, overrun=0.
REQ-030 Reset asserted mid-DIV SHALL abort the divide with no valid pulse.
REQ-031 After reset deassertion, the first rise SHALL only arm; the first valid follows the second rise.

Verification
REQ-032 sel=0, period 1000, high 250 -> first valid after the 2nd rise, duty_out=32; valid exactly 36 cycles after the raw edge.
REQ-033 sel=0, period 10417, high 5209 -> duty_out=64; with high 5208 -> duty_out=63 (floor check).
REQ-034 sel=1, period 200000, high times 15000 / 5000 / 25000 -> duty_out 127 / 0 / 255 respectively.
REQ-035 Period 1000, then pwm_in held low for 400001 cycles -> lost=1, duty_out held, no valid; on resume, 2 rises -> valid, lost=0.
REQ-036 Rises spaced 20 cycles (inside DIV) -> overrun=1 and the in-flight result completes; at the next clean valid, overrun=0.
REQ-037 Assert rst_n at C+10 during DIV -> all outputs 0 immediately, no valid pulse, FSM back in IDLE.
